multicycle_ctrl: RTL

- Multi-cycle main controller for the RV32I datapath (register file, SrcA/SrcB muxes, ALU).
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback states.
- Drives mux selects, ALU control and write enables, and stalls on a memory-ready handshake.
- Replaces single-cycle combinational control; the datapath gains the IR, OldPC, Data and ALUOut registers.

---
 rtl/multicycle_ctrl_pkg.sv | 54 +++++
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl_alu_decoder.sv | 30 +++
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared types, opcodes and select encodings for the multi-cycle RV32I controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_JAL, S_BRANCH, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef logic [2:0] alu_ctrl_t;
  localparam alu_ctrl_t ALU_ADD = 3'b000;
  localparam alu_ctrl_t ALU_SUB = 3'b001;
  localparam alu_ctrl_t ALU_AND = 3'b010;
  localparam alu_ctrl_t ALU_OR  = 3'b011;
  localparam alu_ctrl_t ALU_SLT = 3'b101;

  // Coarse ALU intent handed from the FSM to the decoder
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath/memory signal bundle
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
           instr_done, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
           instr_done, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - maps FSM ALU intent plus funct fields to alu_control
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output alu_ctrl_t  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          // op5 separates R-type (sub possible) from I-type (addi only)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I main controller FSM
// CTRL_PERF_CNT_EN adds cycle_cnt/instret_cnt performance counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]      cycle_cnt,
  output logic [31:0]      instret_cnt
`endif
);

  state_t     state;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
    end else begin
      case (state)
        S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXEC_R;
            OP_ITYPE:          state <= S_EXEC_I;
            OP_JAL:            state <= S_JAL;
            OP_BRANCH:         state <= S_BRANCH;
            default:           state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR:   state <= bus.op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
        S_EXEC_R, S_EXEC_I, S_JAL: state <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BRANCH: state <= S_FETCH;
        S_ILLEGAL:  state <= S_ILLEGAL;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs are gated by rst_n so an asserted reset clears every strobe immediately
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.result_src = RES_ALUOUT;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_RD2;
    bus.imm_src    = IMM_I;
    bus.reg_write  = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    alu_op         = ALU_OP_ADD;
    if (rst_n) begin
      bus.imm_src = imm_sel(bus.op);
      case (state)
        S_FETCH: begin
          bus.mem_req    = 1'b1;
          bus.alu_src_b  = SRCB_FOUR;
          bus.result_src = RES_ALURESULT;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_a = SRCA_OLDPC;
          bus.alu_src_b = SRCB_IMM;
        end
        S_MEMADR: begin
          bus.alu_src_a = SRCA_RD1;
          bus.alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: begin
          bus.mem_req = 1'b1;
          bus.adr_src = 1'b1;
        end
        S_MEMWRITE: begin
          bus.mem_req    = 1'b1;
          bus.adr_src    = 1'b1;
          bus.mem_write  = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        S_MEMWB: begin
          bus.result_src = RES_DATA;
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_EXEC_R: begin
          bus.alu_src_a = SRCA_RD1;
          bus.alu_src_b = SRCB_RD2;
          alu_op        = ALU_OP_FUNCT;
        end
        S_EXEC_I: begin
          bus.alu_src_a = SRCA_RD1;
          bus.alu_src_b = SRCB_IMM;
          alu_op        = ALU_OP_FUNCT;
        end
        S_ALUWB: begin
          bus.result_src = RES_ALUOUT;
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_JAL: begin
          bus.alu_src_a = SRCA_OLDPC;
          bus.alu_src_b = SRCB_FOUR;
          bus.pc_write  = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a  = SRCA_RD1;
          bus.alu_src_b  = SRCB_RD2;
          alu_op         = ALU_OP_SUB;
          bus.instr_done = 1'b1;
          case (bus.funct3)
            3'b000:  bus.pc_write = bus.zero;
            3'b001:  bus.pc_write = ~bus.zero;
            default: bus.pc_write = 1'b0;
          endcase
        end
        S_ILLEGAL: begin
          bus.illegal = 1'b1;
          bus.imm_src = IMM_I;
        end
        default: ;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (bus.alu_control)
  );

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state != S_ILLEGAL) cycle_cnt <= cycle_cnt + 32'd1;
      if (bus.instr_done) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
